// File: rtl/dcache_write_buffer.sv
// Posted-write buffer between the L1 D-cache and slow_memD. Block write-backs are absorbed into a
// coalescing FIFO and drained in the background; read misses are forwarded on a match or go to memory first.
module dcache_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 28,
    parameter int DW    = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cache_read,
    input  logic          cache_write,
    input  logic [AW-1:0] cache_addr,
    input  logic [DW-1:0] cache_wdata,
    output logic [DW-1:0] cache_rdata,
    output logic          cache_ready,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, MEM_RD = 2'd1, MEM_WR = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ent_addr_q [DEPTH];
    logic [AW-1:0] ent_addr_d [DEPTH];
    logic [DW-1:0] ent_data_q [DEPTH];
    logic [DW-1:0] ent_data_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          cache_ready_q, cache_ready_d;
    logic [DW-1:0] cache_rdata_q, cache_rdata_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic          rd_new, wr_new, rd_hit, co_hit, push, pop;
    logic [PW-1:0] rd_idx, co_idx, idx;

    assign rd_new = cache_read && !cache_ready_q;
    assign wr_new = cache_write && !cache_ready_q;
    assign pop    = (state_q == MEM_WR) && mem_ready;
    assign push   = wr_new && !co_hit && ((count_q < (PW+1)'(DEPTH)) || pop);

    // Scan oldest to newest so the newest matching entry wins; the in-flight head never coalesces.
    always_comb begin
        rd_hit = 1'b0;
        co_hit = 1'b0;
        rd_idx = '0;
        co_idx = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (((PW+1)'(k) < count_q) && (ent_addr_q[idx] == cache_addr)) begin
                rd_hit = 1'b1;
                rd_idx = idx;
                if (!((k == 0) && (state_q == MEM_WR))) begin
                    co_hit = 1'b1;
                    co_idx = idx;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ent_addr_d    = ent_addr_q;
        ent_data_d    = ent_data_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        cache_ready_d = 1'b0;
        cache_rdata_d = cache_rdata_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;

        if (rd_new && rd_hit) begin
            cache_rdata_d = ent_data_q[rd_idx];
            cache_ready_d = 1'b1;
        end
        if (wr_new && co_hit) begin
            ent_data_d[co_idx] = cache_wdata;
            cache_ready_d      = 1'b1;
        end
        if (push) begin
            ent_addr_d[tail_q] = cache_addr;
            ent_data_d[tail_q] = cache_wdata;
            tail_d             = tail_q + PW'(1);
            cache_ready_d      = 1'b1;
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW+1)'(1);
        end

        case (state_q)
            IDLE: begin
                if (rd_new && !rd_hit) begin
                    mem_read_d = 1'b1;
                    mem_addr_d = cache_addr;
                    state_d    = MEM_RD;
                end else if (count_q != '0) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = ent_addr_q[head_q];
                    // A coalesce into the head on this same edge must reach memory too.
                    mem_wdata_d = (wr_new && co_hit && (co_idx == head_q)) ? cache_wdata
                                                                           : ent_data_q[head_q];
                    state_d     = MEM_WR;
                end
            end
            MEM_RD: begin
                if (mem_ready) begin
                    cache_rdata_d = mem_rdata;
                    cache_ready_d = 1'b1;
                    mem_read_d    = 1'b0;
                    state_d       = IDLE;
                end
            end
            MEM_WR: begin
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            cache_ready_q <= 1'b0;
            cache_rdata_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            cache_ready_q <= cache_ready_d;
            cache_rdata_q <= cache_rdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            ent_addr_q    <= ent_addr_d;
            ent_data_q    <= ent_data_d;
        end
    end

    assign cache_ready = cache_ready_q;
    assign cache_rdata = cache_rdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Scoreboard bench for dcache_write_buffer: directed cache traffic, a slow-memory responder,
// and a monitor that checks every cache completion and every new memory request in order.
module tb_dcache_write_buffer;
    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk;
    logic          rst_n;
    logic          cache_read, cache_write;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata, cache_rdata;
    logic          cache_ready;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_ready;

    typedef struct {
        logic          is_read;
        logic [DW-1:0] data;
    } cexp_t;

    typedef struct {
        logic          is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mexp_t;

    cexp_t exp_c[$];
    mexp_t exp_m[$];
    int    checks;
    int    errors;
    logic  mem_stall;

    dcache_write_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cache_read  (cache_read),
        .cache_write (cache_write),
        .cache_addr  (cache_addr),
        .cache_wdata (cache_wdata),
        .cache_rdata (cache_rdata),
        .cache_ready (cache_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        return {4{4'hD, a}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_m(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mexp_t e;
        e.is_write = w;
        e.addr     = a;
        e.data     = d;
        exp_m.push_back(e);
    endtask

    // Memory model: answers each request two cycles after it is seen, unless stalled.
    initial begin
        int cnt;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
            end else if ((mem_read || mem_write) && !mem_stall && rst_n) begin
                cnt++;
                if (cnt >= 2) begin
                    mem_ready = 1'b1;
                    mem_rdata = memval(mem_addr);
                    cnt       = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every cache completion and every new memory request.
    initial begin
        logic  pw, pr;
        cexp_t ce;
        mexp_t me;
        pw = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pw = 1'b0;
                pr = 1'b0;
            end else begin
                if (cache_ready) begin
                    if (exp_c.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL cache_unexpected actual=ready required=idle");
                    end else begin
                        ce = exp_c.pop_front();
                        if (ce.is_read) chk("cache_rdata", cache_rdata, ce.data);
                    end
                end
                if ((mem_write && !pw) || (mem_read && !pr)) begin
                    if (exp_m.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_unexpected actual=rd%0d_wr%0d_addr%h required=none",
                                 mem_read, mem_write, mem_addr);
                    end else begin
                        me = exp_m.pop_front();
                        chk("mem_is_write", DW'(mem_write), DW'(me.is_write));
                        chk("mem_is_read", DW'(mem_read), DW'(!me.is_write));
                        chk("mem_addr", DW'(mem_addr), DW'(me.addr));
                        if (me.is_write) chk("mem_wdata", mem_wdata, me.data);
                    end
                end
                pw = mem_write;
                pr = mem_read;
            end
        end
    end

    task automatic do_cache(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int exp_lat, input logic [DW-1:0] exp_rdata, input string name);
        cexp_t e;
        int    lat;
        bit    got;
        e.is_read = rd;
        e.data    = exp_rdata;
        exp_c.push_back(e);
        @(negedge clk);
        cache_read  = rd;
        cache_write = !rd;
        cache_addr  = a;
        cache_wdata = d;
        lat = 0;
        got = 1'b0;
        repeat (100) begin
            @(negedge clk);
            lat++;
            if (cache_ready) begin
                got = 1'b1;
                break;
            end
        end
        cache_read  = 1'b0;
        cache_write = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s actual=timeout required=cache_ready", name);
        end else if (exp_lat > 0) begin
            chk({name, "_latency"}, DW'(lat), DW'(exp_lat));
        end
    endtask

    task automatic wait_mem_write(input string name);
        bit got;
        got = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (mem_write) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s actual=no_mem_write required=mem_write", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int quiet;
        quiet = 0;
        repeat (300) begin
            @(negedge clk);
            if (!mem_read && !mem_write && (exp_m.size() == 0)) quiet++;
            else quiet = 0;
            if (quiet >= 4) break;
        end
        if (quiet < 4) begin
            checks++;
            errors++;
            $display("FAIL %s actual=pending%0d required=drained", name, exp_m.size());
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_cache_ready"}, DW'(cache_ready), '0);
        chk({name, "_cache_rdata"}, cache_rdata, '0);
        chk({name, "_mem_read"}, DW'(mem_read), '0);
        chk({name, "_mem_write"}, DW'(mem_write), '0);
        chk({name, "_mem_addr"}, DW'(mem_addr), '0);
        chk({name, "_mem_wdata"}, mem_wdata, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stalled, stray;
        bit seen;
        checks      = 0;
        errors      = 0;
        mem_stall   = 1'b1;
        cache_read  = 1'b0;
        cache_write = 1'b0;
        cache_addr  = '0;
        cache_wdata = '0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n     = 1'b1;
        mem_stall = 1'b0;

        // Posted write, then a read of the same block after it has drained must miss.
        push_m(1'b1, 28'h10, 128'hAA);
        do_cache(1'b0, 28'h10, 128'hAA, 1, '0, "wr_posted");
        wait_idle("drain_10");
        push_m(1'b0, 28'h10, '0);
        do_cache(1'b1, 28'h10, '0, -1, memval(28'h10), "rd_after_drain");
        wait_idle("rd_10");

        // Forward from buffer while the drain is stalled.
        mem_stall = 1'b1;
        push_m(1'b1, 28'h20, 128'h1);
        do_cache(1'b0, 28'h20, 128'h1, 1, '0, "wr_20");
        wait_mem_write("inflight_20");
        do_cache(1'b1, 28'h20, '0, 1, 128'h1, "fwd_20");
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_read) stray++;
        end
        chk("fwd_no_mem_read", DW'(stray), '0);
        mem_stall = 1'b0;
        wait_idle("drain_20");

        // In-flight head is not coalesced; newest entry is forwarded.
        mem_stall = 1'b1;
        push_m(1'b1, 28'h30, 128'h1);
        do_cache(1'b0, 28'h30, 128'h1, 1, '0, "wr_30_a");
        wait_mem_write("inflight_30");
        push_m(1'b1, 28'h30, 128'h2);
        do_cache(1'b0, 28'h30, 128'h2, 1, '0, "wr_30_b");
        do_cache(1'b1, 28'h30, '0, 1, 128'h2, "fwd_30");
        mem_stall = 1'b0;
        wait_idle("drain_30");

        // Coalesce into a queued (not in-flight) entry keeps one drain with the latest data.
        mem_stall = 1'b1;
        push_m(1'b1, 28'h38, 128'h5);
        do_cache(1'b0, 28'h38, 128'h5, 1, '0, "wr_38");
        wait_mem_write("inflight_38");
        push_m(1'b1, 28'h39, 128'h7);
        do_cache(1'b0, 28'h39, 128'h6, 1, '0, "wr_39_a");
        do_cache(1'b0, 28'h39, 128'h7, 1, '0, "wr_39_coalesce");
        mem_stall = 1'b0;
        wait_idle("drain_39");

        // Full buffer stalls a fifth distinct write until a pop frees a slot.
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_m(1'b1, 28'h50 + AW'(i), 128'h500 + DW'(i));
            do_cache(1'b0, 28'h50 + AW'(i), 128'h500 + DW'(i), 1, '0, "wr_fill");
        end
        push_m(1'b1, 28'h54, 128'h504);
        begin
            cexp_t e;
            e.is_read = 1'b0;
            e.data    = '0;
            exp_c.push_back(e);
        end
        @(negedge clk);
        cache_write = 1'b1;
        cache_addr  = 28'h54;
        cache_wdata = 128'h504;
        stalled = 0;
        repeat (6) begin
            @(negedge clk);
            if (cache_ready) stalled++;
        end
        chk("full_no_ready", DW'(stalled), '0);
        mem_stall = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (mem_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("full_pop_seen", DW'(seen), DW'(1));
        @(negedge clk);
        chk("full_ready_after_pop", DW'(cache_ready), DW'(1));
        cache_write = 1'b0;
        wait_idle("drain_full");

        // A read miss during a drain goes to memory before the next queued write.
        mem_stall = 1'b1;
        push_m(1'b1, 28'h60, 128'h6);
        do_cache(1'b0, 28'h60, 128'h6, 1, '0, "wr_60");
        wait_mem_write("inflight_60");
        push_m(1'b0, 28'h40, '0);
        push_m(1'b1, 28'h61, 128'h7);
        do_cache(1'b0, 28'h61, 128'h7, 1, '0, "wr_61");
        fork
            begin
                repeat (4) @(negedge clk);
                mem_stall = 1'b0;
            end
        join_none
        do_cache(1'b1, 28'h40, '0, -1, memval(28'h40), "rd_miss_40");
        wait_idle("drain_61");

        // Reset in the middle of a drain discards the buffer.
        mem_stall = 1'b1;
        push_m(1'b1, 28'h70, 128'h9);
        do_cache(1'b0, 28'h70, 128'h9, 1, '0, "wr_70");
        wait_mem_write("inflight_70");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("mid_reset");
        @(negedge clk);
        rst_n     = 1'b1;
        mem_stall = 1'b0;
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_write) stray++;
        end
        chk("post_reset_no_write", DW'(stray), '0);
        push_m(1'b0, 28'h70, '0);
        do_cache(1'b1, 28'h70, '0, -1, memval(28'h70), "rd_after_reset");
        wait_idle("final");

        chk("cache_queue_empty", DW'(exp_c.size()), '0);
        chk("mem_queue_empty", DW'(exp_m.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
